// File: rtl/ser_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ser_ctrl_pkg
// Shared types and constants for the MBIST serial chain controller.
//   state_e    : controller FSM states (IDLE, SHIFT, DONE)
//   OP_RD/OP_WR: request opcode encoding on req_wr
//   CHAIN_LEN  : default chain length in bits
//   sel_width(): chain-select width for a given chain count (minimum 1)
// -----------------------------------------------------------------------------
package ser_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam int CHAIN_LEN = 64;

   function automatic int sel_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/ser_rr_arb2.sv
// -----------------------------------------------------------------------------
// ser_rr_arb2
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   advance    : a grant is being taken this cycle; remember the winner
//   gnt_idx    : index of the winning requester (valid with gnt_vld)
//   gnt_vld    : at least one requester is active
// The last-granted port starts at 1 so port 0 wins the first contest.
// -----------------------------------------------------------------------------
module ser_rr_arb2
   import ser_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       gnt_idx,
   output logic       gnt_vld
);

   logic last_q;

   assign gnt_vld = |req;
   // Contention goes to the port that did not win last; otherwise the lone requester.
   assign gnt_idx = (&req) ? ~last_q : req[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (advance) begin
         last_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/ser_chain_ctrl.sv
// -----------------------------------------------------------------------------
// ser_chain_ctrl
// Shares NCH MBIST serial scan chains between two register-bus requesters.
// Each transaction shifts exactly DW bits through one chain: reads recirculate
// sdo back into sdi (non-destructive), writes shift in wdata while capturing the
// old contents (exchange).
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_cs/wr/sel/wdata : per-port request (level), opcode, chain select, data
//   req_rdata           : per-port captured chain contents, held until next ack
//   req_ack/req_err     : one-cycle ack per port; err flags an out-of-range select
//   busy                : controller not idle
//   shift               : one-hot shift enable per chain
//   sdi / sdo           : shared serial data out / per-chain serial data in
// -----------------------------------------------------------------------------
module ser_chain_ctrl
   import ser_ctrl_pkg::*;
#(
   parameter int NCH = 4,
   parameter int DW  = CHAIN_LEN,
   parameter int SW  = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_cs,
   input  logic [1:0]           req_wr,
   input  logic [1:0][SW-1:0]   req_sel,
   input  logic [1:0][DW-1:0]   req_wdata,
   output logic [1:0][DW-1:0]   req_rdata,
   output logic [1:0]           req_ack,
   output logic [1:0]           req_err,
   output logic                 busy,
   output logic [NCH-1:0]       shift,
   output logic                 sdi,
   input  logic [NCH-1:0]       sdo
);

   localparam int            CW       = $clog2(DW) + 1;
   localparam logic [SW:0]   NCH_W    = (SW+1)'(NCH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   state_e                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;
   logic [DW-1:0]         shreg_q, shreg_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [NCH-1:0]        shift_q, shift_d;
   logic [1:0][DW-1:0]    rdata_q, rdata_d;

   logic                  gnt_idx, gnt_vld, grant;
   logic [SW-1:0]         sel_in;
   logic                  sel_ok;
   logic [NCH-1:0]        sel_onehot;
   logic                  sdo_bit;
   logic [DW-1:0]         shreg_shifted;

   ser_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_cs),
      .advance (grant),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign grant  = (state_q == IDLE) && gnt_vld;
   assign sel_in = req_sel[gnt_idx];
   assign sel_ok = {1'b0, sel_in} < NCH_W;

   // Decode the select directly to a one-hot; an out-of-range select decodes to zero.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_sel_dec
      assign sel_onehot[gi] = (sel_in == SW'(gi));
   end

   // shift_q is the latched one-hot of the active chain, so it doubles as the sdo mux.
   assign sdo_bit       = |(sdo & shift_q);
   assign shreg_shifted = {sdo_bit, shreg_q[DW-1:1]};

   // Gated by shift_q so sdi idles at 0 whenever no chain is shifting.
   assign sdi = (|shift_q) & ((wr_q == OP_WR) ? shreg_q[0] : sdo_bit);

   assign busy      = (state_q != IDLE);
   assign shift     = shift_q;
   assign req_rdata = rdata_q;
   assign req_ack   = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
   assign req_err   = err_q ? req_ack : 2'b00;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      wr_d      = wr_q;
      err_d     = err_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rdata_d   = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               gnt_d     = gnt_idx;
               wr_d      = req_wr[gnt_idx];
               shreg_d   = req_wdata[gnt_idx];
               bit_cnt_d = '0;
               if (sel_ok) begin
                  err_d   = 1'b0;
                  shift_d = sel_onehot;
                  state_d = SHIFT;
               end else begin
                  // No chain touched; the port still gets an ack, with err and zero data.
                  err_d            = 1'b1;
                  rdata_d[gnt_idx] = '0;
                  state_d          = DONE;
               end
            end
         end

         SHIFT: begin
            shreg_d = shreg_shifted;
            if (bit_cnt_q == LAST_BIT) begin
               shift_d = '0;
               // Load the result on the way into DONE so it is valid alongside the ack.
               rdata_d[gnt_q] = shreg_shifted;
               state_d        = DONE;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            shift_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         wr_q      <= OP_RD;
         err_q     <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ser_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ser_chain_ctrl
// Directed bench for ser_chain_ctrl with behavioural models of the serial chains.
// Five chains are instantiated so a 3-bit select can address an absent chain.
// -----------------------------------------------------------------------------
module tb_ser_chain_ctrl;

   localparam int NCH = 5;
   localparam int DW  = 64;
   localparam int SW  = 3;

   logic                clk       = 1'b0;
   logic                rst_n     = 1'b1;
   logic [1:0]          req_cs    = '0;
   logic [1:0]          req_wr    = '0;
   logic [1:0][SW-1:0]  req_sel   = '0;
   logic [1:0][DW-1:0]  req_wdata = '0;
   logic [1:0][DW-1:0]  req_rdata;
   logic [1:0]          req_ack;
   logic [1:0]          req_err;
   logic                busy;
   logic [NCH-1:0]      shift;
   logic                sdi;
   logic [NCH-1:0]      sdo;

   int errors = 0;
   int checks = 0;

   // Chain model: sdo is bit 0, sdi enters at the top on each enabled edge.
   logic [DW-1:0] chain [NCH] = '{default: '0};
   int            shift_cnt [NCH] = '{default: 0};
   int            onehot_viol = 0;
   int            sdi_viol = 0;
   logic          pre_en = 1'b0;
   int            pre_idx = 0;
   logic [DW-1:0] pre_val = '0;
   logic          clr_en = 1'b0;

   ser_chain_ctrl #(.NCH(NCH), .DW(DW), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_cs    (req_cs),
      .req_wr    (req_wr),
      .req_sel   (req_sel),
      .req_wdata (req_wdata),
      .req_rdata (req_rdata),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .busy      (busy),
      .shift     (shift),
      .sdi       (sdi),
      .sdo       (sdo)
   );

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_sdo
      assign sdo[gi] = chain[gi][0];
   end

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (pre_en && pre_idx == c) chain[c] <= pre_val;
         else if (shift[c])          chain[c] <= {sdi, chain[c][DW-1:1]};
         if (clr_en)        shift_cnt[c] <= 0;
         else if (shift[c]) shift_cnt[c] <= shift_cnt[c] + 1;
      end
      if ($countones(shift) > 1) onehot_viol <= onehot_viol + 1;
      if (shift == '0 && sdi !== 1'b0) sdi_viol <= sdi_viol + 1;
   end

   task automatic preload(input int c, input logic [DW-1:0] v);
      pre_idx = c; pre_val = v; pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic clear_counts();
      clr_en = 1'b1;
      @(posedge clk); #1;
      clr_en = 1'b0;
   endtask

   // Issues one request and steps until its ack (bounded). Step k = k-th cycle after grant.
   task automatic run_txn(input int p, input logic wr, input logic [SW-1:0] sel,
                          input logic [DW-1:0] wd, output int ack_step,
                          output logic [1:0] ack_seen, output logic err_seen,
                          output int first_sh, output int last_sh);
      req_wr[p] = wr; req_sel[p] = sel; req_wdata[p] = wd; req_cs[p] = 1'b1;
      ack_step = -1; ack_seen = '0; err_seen = 1'b0; first_sh = -1; last_sh = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (|shift) begin
            if (first_sh < 0) first_sh = k;
            last_sh = k;
         end
         if (req_ack != 2'b00) begin
            ack_step = k; ack_seen = req_ack; err_seen = req_err[p];
            req_cs[p] = 1'b0;
            break;
         end
      end
      req_cs[p] = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (shift !== '0) begin errors++; $display("FAIL reset_shift: got %b expected 0", shift); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", req_ack); end
      checks++; if (req_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", req_err); end
      checks++; if (req_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", req_rdata); end
      checks++; if (sdi !== 1'b0) begin errors++; $display("FAIL reset_sdi: got %b expected 0", sdi); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
      $display("txn reset: done");
   endtask

   task automatic test_read();
      int a, f, l; logic [1:0] s; logic e;
      clear_counts();
      preload(2, 64'hDEAD_BEEF_0123_4567);
      run_txn(0, 1'b0, 3'd2, 64'hFFFF_0000_FFFF_0000, a, s, e, f, l);
      checks++; if (a != 65) begin errors++; $display("FAIL read_ack_step: got %0d expected 65", a); end
      checks++; if (s !== 2'b01) begin errors++; $display("FAIL read_ack_port: got %b expected 01", s); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", e); end
      checks++; if (f != 1 || l != 64) begin errors++; $display("FAIL read_shift_window: got %0d..%0d expected 1..64", f, l); end
      checks++; if (shift_cnt[2] != 64) begin errors++; $display("FAIL read_shift_cnt: got %0d expected 64", shift_cnt[2]); end
      checks++; if (req_rdata[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL read_rdata: got %h expected deadbeef01234567", req_rdata[0]); end
      checks++; if (chain[2] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL read_chain_kept: got %h expected deadbeef01234567", chain[2]); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle_after: got busy=%b expected 0", busy); end
      $display("txn read p0 sel2: ack@%0d rdata=%h", a, req_rdata[0]);
   endtask

   task automatic test_write();
      int a, f, l; logic [1:0] s; logic e;
      clear_counts();
      preload(1, 64'h1);
      run_txn(1, 1'b1, 3'd1, 64'hA5A5_5A5A_F0F0_0F0F, a, s, e, f, l);
      checks++; if (a != 65) begin errors++; $display("FAIL write_ack_step: got %0d expected 65", a); end
      checks++; if (s !== 2'b10) begin errors++; $display("FAIL write_ack_port: got %b expected 10", s); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", e); end
      checks++; if (chain[1] !== 64'hA5A5_5A5A_F0F0_0F0F) begin errors++; $display("FAIL write_chain: got %h expected a5a55a5af0f00f0f", chain[1]); end
      checks++; if (req_rdata[1] !== 64'h1) begin errors++; $display("FAIL write_old_data: got %h expected 1", req_rdata[1]); end
      checks++; if (shift_cnt[0] + shift_cnt[2] + shift_cnt[3] + shift_cnt[4] != 0) begin errors++; $display("FAIL write_other_chains: got %0d shifts expected 0", shift_cnt[0] + shift_cnt[2] + shift_cnt[3] + shift_cnt[4]); end
      checks++; if (shift_cnt[1] != 64) begin errors++; $display("FAIL write_shift_cnt: got %0d expected 64", shift_cnt[1]); end
      checks++; if (req_rdata[0] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL write_p0_held: got %h expected deadbeef01234567", req_rdata[0]); end
      $display("txn write p1 sel1: ack@%0d old=%h", a, req_rdata[1]);
   endtask

   task automatic test_last_chain();
      int a, f, l; logic [1:0] s; logic e;
      clear_counts();
      preload(4, 64'h8000_0000_0000_0001);
      run_txn(0, 1'b0, 3'd4, 64'h0, a, s, e, f, l);
      checks++; if (a != 65 || e !== 1'b0) begin errors++; $display("FAIL last_chain_ack: got step=%0d err=%b expected 65/0", a, e); end
      checks++; if (shift_cnt[4] != 64) begin errors++; $display("FAIL last_chain_cnt: got %0d expected 64", shift_cnt[4]); end
      checks++; if (req_rdata[0] !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL last_chain_rdata: got %h expected 8000000000000001", req_rdata[0]); end
      checks++; if (chain[4] !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL last_chain_kept: got %h expected 8000000000000001", chain[4]); end
      $display("txn read p0 sel4: ack@%0d rdata=%h", a, req_rdata[0]);
   endtask

   task automatic test_err();
      int a, f, l; logic [1:0] s; logic e; int total;
      clear_counts();
      run_txn(1, 1'b1, 3'd5, 64'h1234_5678_9ABC_DEF0, a, s, e, f, l);
      total = shift_cnt[0] + shift_cnt[1] + shift_cnt[2] + shift_cnt[3] + shift_cnt[4];
      checks++; if (a != 1) begin errors++; $display("FAIL err_ack_step: got %0d expected 1", a); end
      checks++; if (s !== 2'b10) begin errors++; $display("FAIL err_ack_port: got %b expected 10", s); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", e); end
      checks++; if (req_rdata[1] !== 64'h0) begin errors++; $display("FAIL err_rdata: got %h expected 0", req_rdata[1]); end
      checks++; if (f != -1 || total != 0) begin errors++; $display("FAIL err_no_shift: got first=%0d shifts=%0d expected -1/0", f, total); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || req_err !== 2'b00) begin errors++; $display("FAIL err_idle_after: got busy=%b err=%b expected 0/00", busy, req_err); end
      $display("txn err p1 sel5: ack@%0d err=%b", a, e);
   endtask

   task automatic test_arbitration();
      logic [1:0] order [3];
      int at [3];
      int n;
      bit rearm;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      preload(0, 64'h0F0F_0F0F_1111_2222);
      preload(3, 64'h7777_8888_9999_AAAA);
      for (int i = 0; i < 3; i++) begin order[i] = 2'b00; at[i] = -1; end
      n = 0; rearm = 1'b0;
      req_wr = 2'b00; req_sel[0] = 3'd0; req_sel[1] = 3'd3; req_cs = 2'b11;
      for (int k = 1; k <= 300 && n < 3; k++) begin
         @(posedge clk); #1;
         if (rearm) begin req_cs[0] = 1'b1; rearm = 1'b0; end
         if (req_ack != 2'b00) begin
            order[n] = req_ack; at[n] = k; n++;
            if (req_ack[0]) begin req_cs[0] = 1'b0; if (n == 1) rearm = 1'b1; end
            if (req_ack[1]) req_cs[1] = 1'b0;
         end
      end
      req_cs = 2'b00;
      checks++; if (n != 3) begin errors++; $display("FAIL arb_ack_count: got %0d expected 3", n); end
      checks++; if (order[0] !== 2'b01 || at[0] != 65) begin errors++; $display("FAIL arb_first: got %b@%0d expected 01@65", order[0], at[0]); end
      checks++; if (order[1] !== 2'b10 || at[1] != 131) begin errors++; $display("FAIL arb_second: got %b@%0d expected 10@131", order[1], at[1]); end
      checks++; if (order[2] !== 2'b01 || at[2] != 197) begin errors++; $display("FAIL arb_third: got %b@%0d expected 01@197", order[2], at[2]); end
      checks++; if (req_rdata[0] !== 64'h0F0F_0F0F_1111_2222) begin errors++; $display("FAIL arb_rdata0: got %h expected 0f0f0f0f11112222", req_rdata[0]); end
      checks++; if (req_rdata[1] !== 64'h7777_8888_9999_AAAA) begin errors++; $display("FAIL arb_rdata1: got %h expected 777788889999aaaa", req_rdata[1]); end
      $display("txn arb: acks %b@%0d %b@%0d %b@%0d", order[0], at[0], order[1], at[1], order[2], at[2]);
   endtask

   task automatic test_abort();
      int a, f, l; logic [1:0] s; logic e; logic sh_before;
      clear_counts();
      preload(0, 64'hCAFE_F00D_1357_9BDF);
      req_wr[0] = 1'b0; req_sel[0] = 3'd0; req_cs[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
      end
      sh_before = shift[0];
      rst_n = 1'b0;
      #1;
      checks++; if (sh_before !== 1'b1) begin errors++; $display("FAIL abort_was_shifting: got %b expected 1", sh_before); end
      checks++; if (shift !== '0 || busy !== 1'b0 || req_ack !== 2'b00) begin errors++; $display("FAIL abort_outputs: got shift=%b busy=%b ack=%b expected 0/0/00", shift, busy, req_ack); end
      req_cs = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_counts();
      preload(0, 64'h0123_4567_89AB_CDEF);
      run_txn(0, 1'b0, 3'd0, 64'h0, a, s, e, f, l);
      checks++; if (a != 65 || f != 1 || l != 64) begin errors++; $display("FAIL abort_rerun_timing: got ack=%0d shift=%0d..%0d expected 65 1..64", a, f, l); end
      checks++; if (shift_cnt[0] != 64) begin errors++; $display("FAIL abort_rerun_cnt: got %0d expected 64", shift_cnt[0]); end
      checks++; if (req_rdata[0] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL abort_rerun_rdata: got %h expected 0123456789abcdef", req_rdata[0]); end
      $display("txn abort+reread p0 sel0: ack@%0d rdata=%h", a, req_rdata[0]);
   endtask

   task automatic test_back_to_back();
      bit sh_log [0:200];
      int at [2];
      logic [DW-1:0] rd [2];
      int n;
      logic busy66;
      clear_counts();
      preload(1, 64'h5555_AAAA_3333_CCCC);
      for (int i = 0; i <= 200; i++) sh_log[i] = 1'b0;
      at[0] = -1; at[1] = -1; rd[0] = '0; rd[1] = '0; n = 0; busy66 = 1'bx;
      req_wr[0] = 1'b0; req_sel[0] = 3'd1; req_cs[0] = 1'b1;
      for (int k = 1; k <= 200 && n < 2; k++) begin
         @(posedge clk); #1;
         sh_log[k] = |shift;
         if (k == 66) busy66 = busy;
         if (k == 67) req_cs[0] = 1'b0;
         if (req_ack[0]) begin at[n] = k; rd[n] = req_rdata[0]; n++; end
      end
      req_cs = 2'b00;
      checks++; if (at[0] != 65 || at[1] != 131) begin errors++; $display("FAIL b2b_ack_steps: got %0d,%0d expected 65,131", at[0], at[1]); end
      checks++; if (sh_log[65] !== 1'b0 || sh_log[66] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got shift %b,%b at 65,66 expected 0,0", sh_log[65], sh_log[66]); end
      checks++; if (sh_log[67] !== 1'b1) begin errors++; $display("FAIL b2b_restart: got shift %b at 67 expected 1", sh_log[67]); end
      checks++; if (busy66 !== 1'b0) begin errors++; $display("FAIL b2b_idle_cycle: got busy=%b expected 0", busy66); end
      checks++; if (shift_cnt[1] != 128) begin errors++; $display("FAIL b2b_shift_cnt: got %0d expected 128", shift_cnt[1]); end
      checks++; if (rd[0] !== 64'h5555_AAAA_3333_CCCC || rd[1] !== 64'h5555_AAAA_3333_CCCC) begin errors++; $display("FAIL b2b_rdata: got %h,%h expected 5555aaaa3333cccc", rd[0], rd[1]); end
      $display("txn back-to-back p0 sel1: acks@%0d,%0d", at[0], at[1]);
   endtask

   task automatic test_monitors();
      checks++; if (onehot_viol != 0) begin errors++; $display("FAIL shift_onehot: got %0d violations expected 0", onehot_viol); end
      checks++; if (sdi_viol != 0) begin errors++; $display("FAIL sdi_idle_zero: got %0d violations expected 0", sdi_viol); end
      $display("txn monitors: onehot_viol=%0d sdi_viol=%0d", onehot_viol, sdi_viol);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_last_chain();
      test_err();
      test_arbitration();
      test_abort();
      test_back_to_back();
      test_monitors();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
